pbkdf2_stream_adapter: RTL and testbench
========================================

Name: pbkdf2_stream_adapter

Overview:
Host-side counterpart of the pbkdf2 core's request/result handshake. Assembles a 34-word 32-bit input frame (iteration count, salt length, password, salt) into the core's wide parallel request and drives the core's in_valid/in_ready handshake. It then accepts the 256-bit result on the core's out_valid/out_ready handshake and streams it back out as 8 words. It sits between the narrow host stream bus and the pbkdf2 core.

Parameters:
WORD_W, 32, stream data width; the frame layout below is fixed for 32.
HASH_WORDS, 8, output words per result (256 / WORD_W).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
s_data_i  in  32  input frame word
s_valid_i  in  1  input word valid
s_ready_o  out  1  adapter accepts an input word
m_data_o  out  32  result word
m_valid_o  out  1  result word valid
m_ready_i  in  1  downstream accepts a result word
m_last_o  out  1  marks the 8th result word
core_iters_o  out  32  to pbkdf2 iters_i
core_pass_o  out  513  to pbkdf2 pass_i; bit 512 is always 0
core_salt_o  out  513  to pbkdf2 salt_i; bit 512 is always 0
core_salt_len_o  out  6  to pbkdf2 salt_len_i
core_valid_o  out  1  to pbkdf2 in_valid
core_ready_i  in  1  from pbkdf2 in_ready
core_hash_i  in  256  from pbkdf2 hash_o
core_valid_i  in  1  from pbkdf2 out_valid
core_ready_o  out  1  to pbkdf2 out_ready
busy_o  out  1  high in every state except LOAD
err_o  out  1  one-cycle pulse: frame rejected

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- On reset: state goes to LOAD, word counter to 0, and all field, hash and shift registers clear to 0. m_valid_o, m_last_o, core_valid_o, core_ready_o, err_o and busy_o are 0. s_ready_o is 1 from the first cycle after reset.
- Reset mid-operation in any state abandons the frame or result. The partially loaded frame is discarded and no err_o pulse is produced.
- A transfer occurs on any interface only in a cycle where that interface's valid and ready are both 1.
- Input frame layout, by word index:
  - W0 is the iteration count.
  - W1 carries salt_len in bits [5:0]; bits [31:6] are ignored.
  - W2..W17 are the password, big-endian: W2 lands in pass[511:480] and W17 in pass[31:0].
  - W18..W33 are the salt, laid out the same way.
- State LOAD:
  - s_ready_o = 1.
  - Each transfer writes the word into its field and increments the counter, which runs 0..33.
  - On the transfer of W33:
    - If iters == 0, pulse err_o for the next cycle, reset the counter to 0 and stay in LOAD. The core is never started.
    - Otherwise reset the counter to 0 and go to ISSUE.
- State ISSUE:
  - core_valid_o = 1 and s_ready_o = 0.
  - All core_* request fields stay stable until the handshake completes.
  - When core_ready_i = 1, go to WAIT.
  - core_valid_o must not depend combinationally on core_ready_i, because the core's in_ready depends on in_valid.
- State WAIT:
  - core_ready_o = 1.
  - When core_valid_i = 1, latch core_hash_i into a 256-bit shift register and go to SEND.
  - core_hash_i is sampled only in that handshake cycle.
- State SEND:
  - m_valid_o = 1 and m_data_o = shift[255:224], so word 0 is hash[255:224].
  - Each transfer shifts the register left by 32 bits and increments the output counter.
  - m_last_o = 1 while the output counter == 7.
  - The transfer with m_last_o = 1 returns the state to LOAD.
  - m_data_o stays stable while m_valid_o = 1 and m_ready_i = 0.
- Latency:
  - W33 accepted in cycle N gives core_valid_o = 1 in cycle N+1.
  - Hash captured in cycle M gives m_valid_o = 1 in cycle M+1.
  - With m_ready_i held at 1, the result takes 8 consecutive cycles.
- No pipelining: a new frame is accepted only after the last result word has been transferred.
- Input words presented outside LOAD are not consumed, because s_ready_o = 0.
- The fields keep their values after the handshake until the next frame overwrites them.

Test Plan:
- Nominal run: frame with iters=1, salt_len=4, pass W2=0x70617373 followed by zeros, salt W18=0x73616C74 followed by zeros. Expect core_iters_o=1, core_salt_len_o=4 and core_pass_o[511:480]=0x70617373 while core_valid_o is high. Model the core returning hash 0x00010203…1C1D1E1F. Expect 8 output words 0x00010203, 0x04050607, …, 0x1C1D1E1F, with m_last_o set only on the 8th.
- Backpressure: as above, but toggle m_ready_i 1-0-0-1 repeatedly and drop s_valid_i every other cycle during load. Expect no words lost or duplicated, m_data_o stable while stalled, and exactly 34 input transfers.
- iters=0 frame: expect an err_o pulse in the cycle after W33, core_valid_o never asserted, and s_ready_o still 1. A following valid frame must complete normally.
- Core stalls: core_ready_i held at 0 for 20 cycles. Expect core_valid_o held at 1, request fields unchanged, s_ready_o=0 and busy_o=1.
- Reset mid-frame after W10, then reset again in SEND after 3 words: expect all outputs 0, the state back in LOAD, and a fresh 34-word frame producing a correct result.
- Salt-length boundary: salt_len field W1=0xFFFFFFFF. Expect core_salt_len_o=63 with the upper bits ignored.

Source files
------------

// File: rtl/pbkdf2_stream_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : pbkdf2_stream_adapter_if
// Description : Bundles the host input stream, host result stream and the
//               pbkdf2 core request/result handshake into one bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface pbkdf2_stream_adapter_if;
   // host input stream
   logic [31:0]  s_data_i;
   logic         s_valid_i;
   logic         s_ready_o;
   // host result stream
   logic [31:0]  m_data_o;
   logic         m_valid_o;
   logic         m_ready_i;
   logic         m_last_o;
   // pbkdf2 core request
   logic [31:0]  core_iters_o;
   logic [512:0] core_pass_o;
   logic [512:0] core_salt_o;
   logic [5:0]   core_salt_len_o;
   logic         core_valid_o;
   logic         core_ready_i;
   // pbkdf2 core result
   logic [255:0] core_hash_i;
   logic         core_valid_i;
   logic         core_ready_o;

   // adapter side
   modport slave (
      input  s_data_i, s_valid_i, m_ready_i, core_ready_i, core_hash_i, core_valid_i,
      output s_ready_o, m_data_o, m_valid_o, m_last_o, core_iters_o, core_pass_o,
             core_salt_o, core_salt_len_o, core_valid_o, core_ready_o
   );

   // host / core environment side
   modport master (
      output s_data_i, s_valid_i, m_ready_i, core_ready_i, core_hash_i, core_valid_i,
      input  s_ready_o, m_data_o, m_valid_o, m_last_o, core_iters_o, core_pass_o,
             core_salt_o, core_salt_len_o, core_valid_o, core_ready_o
   );
endinterface
`default_nettype wire

// File: rtl/pbkdf2_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : pbkdf2_stream_adapter
// Description : Collects a 34-word frame into the pbkdf2 core's wide request,
//               runs the core handshakes and streams the 256-bit result back
//               out as 8 words, most significant word first.
// Revision    : 1.0 - initial release
// ============================================================================
module pbkdf2_stream_adapter #(
   parameter int WORD_W     = 32,
   parameter int HASH_WORDS = 8
) (
   input  wire logic                    clk_i,
   input  wire logic                    rst_i,
   pbkdf2_stream_adapter_if.slave       bus,
   output logic                         busy_o,
   output logic                         err_o
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_SEND  = 2'd3
   } state_t;

   localparam logic [5:0] C_LAST_WORD = 6'd33;
   localparam logic [2:0] C_LAST_OUT  = 3'(HASH_WORDS - 1);

   state_t       state_q,    state_d;
   logic [5:0]   cnt_q,      cnt_d;
   logic [2:0]   ocnt_q,     ocnt_d;
   logic [31:0]  iters_q,    iters_d;
   logic [5:0]   salt_len_q, salt_len_d;
   logic [511:0] pass_q,     pass_d;
   logic [511:0] salt_q,     salt_d;
   logic [255:0] shift_q,    shift_d;
   logic         err_q,      err_d;

   // State and datapath registers; reset discards any partial frame or result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_LOAD;
         cnt_q      <= '0;
         ocnt_q     <= '0;
         iters_q    <= '0;
         salt_len_q <= '0;
         pass_q     <= '0;
         salt_q     <= '0;
         shift_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ocnt_q     <= ocnt_d;
         iters_q    <= iters_d;
         salt_len_q <= salt_len_d;
         pass_q     <= pass_d;
         salt_q     <= salt_d;
         shift_q    <= shift_d;
         err_q      <= err_d;
      end
   end

   // Next-state, field capture and handshake outputs; valids depend on state only
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ocnt_d     = ocnt_q;
      iters_d    = iters_q;
      salt_len_d = salt_len_q;
      pass_d     = pass_q;
      salt_d     = salt_q;
      shift_d    = shift_q;
      err_d      = 1'b0;

      bus.s_ready_o    = 1'b0;
      bus.core_valid_o = 1'b0;
      bus.core_ready_o = 1'b0;
      bus.m_valid_o    = 1'b0;

      case (state_q)
         ST_LOAD: begin
            bus.s_ready_o = 1'b1;
            if (bus.s_valid_i) begin
               if (cnt_q == 6'd0) iters_d    = bus.s_data_i;
               if (cnt_q == 6'd1) salt_len_d = bus.s_data_i[5:0];
               // password and salt words arrive most significant first
               for (int i = 0; i < 16; i++) begin
                  if (cnt_q == 6'(i + 2))  pass_d[511 - 32*i -: 32] = bus.s_data_i;
                  if (cnt_q == 6'(i + 18)) salt_d[511 - 32*i -: 32] = bus.s_data_i;
               end
               if (cnt_q == C_LAST_WORD) begin
                  cnt_d = 6'd0;
                  // a zero iteration count is rejected without starting the core
                  if (iters_q == 32'd0) err_d   = 1'b1;
                  else                  state_d = ST_ISSUE;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         ST_ISSUE: begin
            bus.core_valid_o = 1'b1;
            if (bus.core_ready_i) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            bus.core_ready_o = 1'b1;
            if (bus.core_valid_i) begin
               shift_d = bus.core_hash_i;
               ocnt_d  = 3'd0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            bus.m_valid_o = 1'b1;
            if (bus.m_ready_i) begin
               shift_d = {shift_q[255-WORD_W:0], {WORD_W{1'b0}}};
               ocnt_d  = ocnt_q + 3'd1;
               if (ocnt_q == C_LAST_OUT) state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   assign bus.m_data_o        = shift_q[255 -: WORD_W];
   assign bus.m_last_o        = (state_q == ST_SEND) && (ocnt_q == C_LAST_OUT);
   assign bus.core_iters_o    = iters_q;
   assign bus.core_salt_len_o = salt_len_q;
   assign bus.core_pass_o     = {1'b0, pass_q};
   assign bus.core_salt_o     = {1'b0, salt_q};
   assign busy_o              = (state_q != ST_LOAD);
   assign err_o               = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pbkdf2_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pbkdf2_stream_adapter
// Description : Directed bench for pbkdf2_stream_adapter with a result
//               scoreboard and a behavioural pbkdf2 core handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pbkdf2_stream_adapter;

   logic clk = 1'b0;
   logic rst;
   logic busy, err;
   always #5 clk = ~clk;

   pbkdf2_stream_adapter_if bus ();

   pbkdf2_stream_adapter #(.WORD_W(32), .HASH_WORDS(8)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus),
      .busy_o (busy),
      .err_o  (err)
   );

   int           n_checks = 0;
   int           n_errors = 0;
   int           in_xfers = 0;
   logic [31:0]  exp_q[$];
   logic [31:0]  frame[34];
   logic [3:0]   bp_pat = 4'b1001;

   // independent count of accepted input words
   always @(posedge clk) begin
      if (!rst && bus.s_valid_i && bus.s_ready_o) in_xfers <= in_xfers + 1;
   end

   task automatic chk(input string tag, input logic [512:0] obs, input logic [512:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] ramp_hash();
      logic [255:0] h;
      for (int b = 0; b < 32; b++) h[255 - 8*b -: 8] = 8'(b);
      return h;
   endfunction

   function automatic logic [255:0] rand_hash();
      logic [255:0] h;
      for (int k = 0; k < 8; k++) h[32*k +: 32] = $urandom;
      return h;
   endfunction

   function automatic logic [512:0] exp_field(input int base);
      logic [512:0] f;
      f = '0;
      for (int i = 0; i < 16; i++) f[511 - 32*i -: 32] = frame[base + i];
      return f;
   endfunction

   task automatic build_frame(input logic [31:0] it, input logic [31:0] sl,
                              input logic [31:0] p0, input logic [31:0] s0, input bit rnd);
      for (int i = 0; i < 34; i++) frame[i] = rnd ? $urandom : 32'd0;
      frame[0]  = it;
      frame[1]  = sl;
      frame[2]  = p0;
      frame[18] = s0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.s_valid_i = 1'b0; bus.m_ready_i = 1'b0;
      bus.core_ready_i = 1'b0; bus.core_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_core_valid", bus.core_valid_o, 1'b0);
      chk("rst_core_ready", bus.core_ready_o, 1'b0);
      chk("rst_m_valid", bus.m_valid_o, 1'b0);
      chk("rst_m_last", bus.m_last_o, 1'b0);
      chk("rst_m_data", bus.m_data_o, 32'd0);
      chk("rst_iters", bus.core_iters_o, 32'd0);
      chk("rst_salt_len", bus.core_salt_len_o, 6'd0);
      chk("rst_pass", bus.core_pass_o, 513'd0);
      chk("rst_salt", bus.core_salt_o, 513'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_s_ready", bus.s_ready_o, 1'b1);
   endtask

   // drives words 0..n-1; returns at the negedge after the last acceptance
   task automatic send_words(input int n, input bit gap);
      int  idx = 0;
      int  cyc = 0;
      bit  tog = 1'b0;
      while (idx < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (gap && tog) begin
            bus.s_valid_i = 1'b0;
         end else begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = frame[idx];
            if (bus.s_ready_o) idx++;
         end
         tog = ~tog;
      end
      @(negedge clk);
      bus.s_valid_i = 1'b0;
      chk("send_timeout", 32'(idx), 32'(n));
   endtask

   task automatic check_issue(input string tag);
      chk({tag, "_core_valid"}, bus.core_valid_o, 1'b1);
      chk({tag, "_s_ready"}, bus.s_ready_o, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_iters"}, bus.core_iters_o, frame[0]);
      chk({tag, "_salt_len"}, bus.core_salt_len_o, frame[1][5:0]);
      chk({tag, "_pass"}, bus.core_pass_o, exp_field(2));
      chk({tag, "_salt"}, bus.core_salt_o, exp_field(18));
   endtask

   // core model: stall in_ready, accept, then return hash after a short delay
   task automatic serve_core(input int stall, input logic [255:0] h);
      for (int k = 0; k < stall; k++) begin
         bus.core_ready_i = 1'b0;
         @(negedge clk);
         check_issue("stall");
      end
      bus.core_ready_i = 1'b1;
      @(negedge clk);
      bus.core_ready_i = 1'b0;
      bus.core_hash_i  = ~h;
      chk("wait_core_valid", bus.core_valid_o, 1'b0);
      repeat (2) begin
         chk("wait_core_ready", bus.core_ready_o, 1'b1);
         @(negedge clk);
      end
      bus.core_valid_i = 1'b1;
      bus.core_hash_i  = h;
      for (int k = 0; k < 8; k++) exp_q.push_back(h[255 - 32*k -: 32]);
      @(negedge clk);
      bus.core_valid_i = 1'b0;
      bus.core_hash_i  = ~h;
      chk("send_m_valid_first", bus.m_valid_o, 1'b1);
      chk("send_core_ready", bus.core_ready_o, 1'b0);
   endtask

   // result sink with optional 1-0-0-1 backpressure; stops after max_words
   task automatic recv(input int max_words, input bit bp);
      int          got = 0;
      int          cyc = 0;
      bit          stalled = 1'b0;
      logic [31:0] prev = '0;
      logic [31:0] w;
      while (got < max_words && exp_q.size() > 0 && cyc < 200) begin
         bus.m_ready_i = bp ? bp_pat[cyc % 4] : 1'b1;
         chk("out_m_valid", bus.m_valid_o, 1'b1);
         if (stalled) chk("out_stable", bus.m_data_o, prev);
         chk("out_last", bus.m_last_o, (exp_q.size() == 1));
         if (bus.m_ready_i) begin
            w = exp_q.pop_front();
            chk("out_data", bus.m_data_o, w);
            got++;
         end
         stalled = !bus.m_ready_i;
         prev    = bus.m_data_o;
         @(negedge clk);
         cyc++;
      end
      bus.m_ready_i = 1'b0;
      chk("recv_timeout", 32'(got), 32'(max_words));
   endtask

   task automatic check_idle();
      chk("idle_s_ready", bus.s_ready_o, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_m_valid", bus.m_valid_o, 1'b0);
   endtask

   initial begin
      int base;
      logic [255:0] h;
      bus.s_data_i = '0; bus.s_valid_i = 1'b0; bus.m_ready_i = 1'b0;
      bus.core_ready_i = 1'b0; bus.core_hash_i = '0; bus.core_valid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      do_reset();

      // nominal frame and ramp hash
      build_frame(32'd1, 32'd4, 32'h70617373, 32'h73616C74, 1'b0);
      send_words(34, 1'b0);
      check_issue("nom");
      chk("nom_iters_val", bus.core_iters_o, 32'd1);
      chk("nom_salt_len_val", bus.core_salt_len_o, 6'd4);
      chk("nom_pass_top", bus.core_pass_o[511:480], 32'h70617373);
      serve_core(0, ramp_hash());
      chk("nom_first_word", bus.m_data_o, 32'h00010203);
      recv(8, 1'b0);
      check_idle();

      // input gaps and output backpressure, random frame contents
      build_frame(32'd1000, 32'd20, $urandom, $urandom, 1'b1);
      base = in_xfers;
      send_words(34, 1'b1);
      chk("bp_in_xfers", 32'(in_xfers - base), 32'd34);
      check_issue("bp");
      serve_core(0, rand_hash());
      recv(8, 1'b1);
      check_idle();

      // zero iteration count is rejected
      build_frame(32'd0, 32'd4, 32'h11111111, 32'h22222222, 1'b0);
      send_words(34, 1'b0);
      chk("zero_err_pulse", err, 1'b1);
      chk("zero_core_valid", bus.core_valid_o, 1'b0);
      chk("zero_s_ready", bus.s_ready_o, 1'b1);
      @(negedge clk);
      chk("zero_err_clear", err, 1'b0);
      repeat (3) begin
         chk("zero_no_issue", bus.core_valid_o, 1'b0);
         @(negedge clk);
      end
      build_frame(32'd7, 32'd8, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1);
      send_words(34, 1'b0);
      check_issue("after_zero");
      serve_core(0, rand_hash());
      recv(8, 1'b0);
      check_idle();

      // core holds in_ready low for 20 cycles
      build_frame(32'h0000_1000, 32'd16, 32'h01234567, 32'h89ABCDEF, 1'b1);
      send_words(34, 1'b0);
      check_issue("pre_stall");
      serve_core(20, rand_hash());
      recv(8, 1'b0);
      check_idle();

      // reset after W10, then reset during SEND after 3 words
      build_frame(32'd5, 32'd12, 32'hAAAA5555, 32'h5555AAAA, 1'b1);
      send_words(11, 1'b0);
      do_reset();
      send_words(34, 1'b0);
      check_issue("after_rst1");
      h = rand_hash();
      serve_core(0, h);
      recv(3, 1'b0);
      do_reset();
      exp_q.delete();
      build_frame(32'd3, 32'd32, 32'h0BADC0DE, 32'h600DF00D, 1'b1);
      send_words(34, 1'b0);
      check_issue("after_rst2");
      serve_core(0, ramp_hash());
      recv(8, 1'b0);
      check_idle();

      // salt length upper bits ignored
      build_frame(32'd2, 32'hFFFF_FFFF, 32'h70617373, 32'h73616C74, 1'b0);
      send_words(34, 1'b0);
      chk("slen_boundary", bus.core_salt_len_o, 6'd63);
      check_issue("slen");
      serve_core(0, rand_hash());
      recv(8, 1'b0);
      check_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
